// File: rtl/trig_ratio_seq_if.sv
// Handshake bundle for the sequential tan/cot unit: operand request channel
// (in_valid/in_ready) and result channel (out_valid/out_ready).
interface trig_ratio_seq_if #(
   parameter int WIDTH = 16
) ();
   logic                    in_valid;
   logic                    in_ready;
   logic                    mode;
   logic signed [WIDTH-1:0] sin_in;
   logic signed [WIDTH-1:0] cos_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] result;
   logic                    div_zero;
   logic                    sat;

   // Producer/consumer side: drives operands and accepts results.
   modport master (
      output in_valid, mode, sin_in, cos_in, out_ready,
      input  in_ready, out_valid, result, div_zero, sat
   );

   // Divider side: accepts operands and presents results.
   modport slave (
      input  in_valid, mode, sin_in, cos_in, out_ready,
      output in_ready, out_valid, result, div_zero, sat
   );
endinterface

// File: rtl/trig_ratio_seq.sv
// Sequential signed tan/cot unit. Computes num*SCALE/den with a restoring
// divider (one quotient bit per cycle), then applies sign, saturation and
// divide-by-zero clamping. Fixed latency: PROD_W+2 cycles from accept.
module trig_ratio_seq #(
   parameter int WIDTH = 16,
   parameter int SCALE = 10000
) (
   input  logic             clk,
   input  logic             rst,
   trig_ratio_seq_if.slave  bus
);
   localparam int PROD_W = 2 * WIDTH;
   localparam int CNT_W  = $clog2(PROD_W);

   localparam logic signed [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [PROD_W-1:0]       SCALE_P = PROD_W'(SCALE);
   localparam logic [PROD_W-1:0]       LIM_POS = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [PROD_W-1:0]       LIM_NEG = {{(PROD_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(PROD_W - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_DIV  = 3'd2,
      S_FIN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Magnitude of a two's complement value; the most negative value maps to
   // 2**(WIDTH-1), which still fits in WIDTH unsigned bits.
   function automatic logic [WIDTH-1:0] abs_f(input logic signed [WIDTH-1:0] v);
      abs_f = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   state_t                  r_state;
   logic signed [WIDTH-1:0] r_num;
   logic signed [WIDTH-1:0] r_den;
   logic                    r_neg;
   logic                    r_dz;
   logic [PROD_W-1:0]       r_dividend;   // shifts out dividend bits, shifts in quotient bits
   logic [WIDTH-1:0]        r_divisor;
   logic [WIDTH-1:0]        r_rem;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_out_valid;
   logic signed [WIDTH-1:0] r_result;
   logic                    r_div_zero;
   logic                    r_sat;

   logic [WIDTH:0]          w_rem_shift;
   logic [WIDTH:0]          w_trial;
   logic                    w_ge;
   logic [WIDTH-1:0]        w_num_abs;
   logic [WIDTH-1:0]        w_den_abs;
   logic [PROD_W-1:0]       w_lim;
   logic [WIDTH-1:0]        w_q_lo;

   // Restoring step: the partial remainder is always below the divisor, so
   // the shifted value fits WIDTH+1 bits and the trial's top bit is the borrow.
   assign w_rem_shift = {r_rem, r_dividend[PROD_W-1]};
   assign w_trial     = w_rem_shift - {1'b0, r_divisor};
   assign w_ge        = ~w_trial[WIDTH];
   assign w_num_abs   = abs_f(r_num);
   assign w_den_abs   = abs_f(r_den);
   assign w_lim       = r_neg ? LIM_NEG : LIM_POS;
   assign w_q_lo      = r_dividend[WIDTH-1:0];

   assign bus.in_ready  = (r_state == S_IDLE) && !rst;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.div_zero  = r_div_zero;
   assign bus.sat       = r_sat;

   // Control FSM and datapath: capture, load, divide, finalise, hold result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_num       <= '0;
         r_den       <= '0;
         r_neg       <= 1'b0;
         r_dz        <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_div_zero  <= 1'b0;
         r_sat       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_num   <= bus.mode ? bus.cos_in : bus.sin_in;
                  r_den   <= bus.mode ? bus.sin_in : bus.cos_in;
                  r_state <= S_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               r_neg      <= r_num[WIDTH-1] ^ r_den[WIDTH-1];
               r_dividend <= {{(PROD_W-WIDTH){1'b0}}, w_num_abs} * SCALE_P;
               r_divisor  <= w_den_abs;
               r_dz       <= (r_den == {WIDTH{1'b0}});
               r_rem      <= '0;
               r_cnt      <= '0;
               r_state    <= S_DIV;
            end
            S_DIV: begin
               r_rem      <= w_ge ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
               r_dividend <= {r_dividend[PROD_W-2:0], w_ge};
               r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_FIN;
               end else begin
                  r_state <= S_DIV;
               end
            end
            S_FIN: begin
               if (r_dz) begin
                  r_result   <= r_num[WIDTH-1] ? MIN_V : MAX_V;
                  r_div_zero <= 1'b1;
                  r_sat      <= 1'b1;
               end else if (r_dividend > w_lim) begin
                  r_result   <= r_neg ? MIN_V : MAX_V;
                  r_div_zero <= 1'b0;
                  r_sat      <= 1'b1;
               end else begin
                  // Negating a zero quotient yields zero, so no special case.
                  r_result   <= r_neg ? (~w_q_lo + {{(WIDTH-1){1'b0}}, 1'b1}) : w_q_lo;
                  r_div_zero <= 1'b0;
                  r_sat      <= 1'b0;
               end
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_trig_ratio_seq.sv
// Self-checking bench for trig_ratio_seq: directed cases from the datasheet
// plus randomized operands compared against an integer-arithmetic model.
module tb_trig_ratio_seq;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   trig_ratio_seq_if #(.WIDTH(16)) bus ();

   trig_ratio_seq #(.WIDTH(16), .SCALE(10000)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain signed arithmetic, truncation toward zero, then clamp.
   task automatic model(input logic m, input logic signed [15:0] s, input logic signed [15:0] c,
                        output logic signed [15:0] r, output logic dz, output logic st);
      longint num;
      longint den;
      longint q;
      num = m ? longint'(c) : longint'(s);
      den = m ? longint'(s) : longint'(c);
      if (den == 0) begin
         dz = 1'b1;
         st = 1'b1;
         r  = (num >= 0) ? 16'sd32767 : -16'sd32768;
      end else begin
         dz = 1'b0;
         q  = (num * 10000) / den;
         if (q > 32767) begin
            r = 16'sd32767; st = 1'b1;
         end else if (q < -32768) begin
            r = -16'sd32768; st = 1'b1;
         end else begin
            r = 16'(q); st = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction: accept, latency check, result check, hold
   // with out_ready low for 'hold' cycles (poking in_valid), then handshake.
   task automatic do_op(input logic m, input logic signed [15:0] s, input logic signed [15:0] c,
                        input int hold);
      logic signed [15:0] er;
      logic               edz;
      logic               est;
      logic signed [15:0] held;
      int                 lat;
      model(m, s, c, er, edz, est);
      chk("in_ready_idle", 64'(bus.in_ready), 64'sd1);
      bus.in_valid = 1'b1;
      bus.mode     = m;
      bus.sin_in   = s;
      bus.cos_in   = c;
      tick();
      bus.in_valid = 1'b0;
      bus.sin_in   = 16'(int'($urandom_range(65535)));
      bus.cos_in   = 16'(int'($urandom_range(65535)));
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         if (lat == 5) chk("in_ready_busy", 64'(bus.in_ready), 64'sd0);
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'sd34);
      chk("result", 64'(bus.result), 64'(er));
      chk("div_zero", 64'(bus.div_zero), 64'(edz));
      chk("sat", 64'(bus.sat), 64'(est));
      held = bus.result;
      for (int k = 0; k < hold; k++) begin
         bus.in_valid = k[0];
         bus.mode     = ~m;
         tick();
         chk("hold_valid", 64'(bus.out_valid), 64'sd1);
         chk("hold_result", 64'(bus.result), 64'(held));
         chk("hold_in_ready", 64'(bus.in_ready), 64'sd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("valid_drop", 64'(bus.out_valid), 64'sd0);
      chk("result_kept", 64'(bus.result), 64'(held));
   endtask

   initial begin
      int lat;
      logic signed [15:0] rs;
      logic signed [15:0] rc;
      n_vec = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.mode      = 1'b0;
      bus.sin_in    = 16'sd0;
      bus.cos_in    = 16'sd0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 64'(bus.in_ready), 64'sd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'sd0);
      chk("rst_result", 64'(bus.result), 64'sd0);
      chk("rst_div_zero", 64'(bus.div_zero), 64'sd0);
      chk("rst_sat", 64'(bus.sat), 64'sd0);
      rst = 1'b0;
      tick();

      do_op(1'b0, 16'sd7071, 16'sd7071, 5);
      do_op(1'b0, 16'sd5000, 16'sd8660, 0);
      do_op(1'b1, 16'sd5000, 16'sd8660, 1);
      do_op(1'b0, -16'sd5000, 16'sd8660, 2);
      do_op(1'b0, 16'sd10000, 16'sd1, 0);
      do_op(1'b0, -16'sd10000, 16'sd1, 0);
      do_op(1'b1, 16'sd0, 16'sd10000, 0);
      do_op(1'b1, 16'sd0, -16'sd10000, 0);
      do_op(1'b0, 16'sd0, -16'sd7, 0);
      do_op(1'b0, -16'sd32768, -16'sd32768, 0);
      do_op(1'b0, 16'sd32767, -16'sd10000, 0);

      // Reset during DIV iteration 10: the op must vanish without a result.
      bus.in_valid = 1'b1;
      bus.mode     = 1'b0;
      bus.sin_in   = 16'sd7071;
      bus.cos_in   = 16'sd7071;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 11; k++) tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", 64'(bus.in_ready), 64'sd0);
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", 64'(bus.out_valid), 64'sd0);
      chk("rst_mid_result", 64'(bus.result), 64'sd0);
      chk("rst_mid_sat", 64'(bus.sat), 64'sd0);
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.out_valid) lat++;
         tick();
      end
      chk("rst_mid_no_result", 64'(lat), 64'sd0);
      do_op(1'b0, 16'sd7071, 16'sd7071, 0);

      // Randomized operands, with occasional small or zero denominators.
      for (int n = 0; n < 24; n++) begin
         rs = 16'(int'($urandom_range(20000)) - 10000);
         rc = 16'(int'($urandom_range(20000)) - 10000);
         case (n % 4)
            0: rc = 16'(int'($urandom_range(8)) - 4);
            1: rs = 16'(int'($urandom_range(65535)));
            default: ;
         endcase
         do_op(1'($urandom_range(1)), rs, rc, int'($urandom_range(3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
